// File: rtl/is_pkg.sv
// Shared definitions for the issue queue: default geometry, source operand
// layout, entry status flags and dispatch channel numbering.
package is_pkg;

  localparam int unsigned ISQ_DEPTH     = 64;
  localparam int unsigned ISQ_IDX_W     = 6;
  localparam int unsigned ISQ_ALLOC_W   = 4;
  localparam int unsigned ISQ_FU_N      = 4;
  localparam int unsigned ISQ_WAKE_N    = 4;
  localparam int unsigned ISQ_PREG_W    = 7;
  localparam int unsigned ISQ_PAYLOAD_W = 48;

  // Source operand field is {pend, tag}: tag in the low PREG_W bits, pend just above.
  localparam int unsigned SRC_TAG_LSB = 0;

  function automatic int unsigned src_pend_pos(input int unsigned preg_w);
    return preg_w;
  endfunction

  // Dispatch channel numbering (bit f of an entry's fu mask)
  localparam int unsigned FU_CH0 = 0;
  localparam int unsigned FU_CH1 = 1;
  localparam int unsigned FU_CH2 = 2;
  localparam int unsigned FU_CH3 = 3;

  // Per-entry status bits kept under reset
  typedef struct packed {
    logic vld;
    logic r1;
    logic r2;
  } ent_flags_t;

endpackage

// File: rtl/isq_age_pick.sv
// Oldest-first picker: scans request bits starting at head and grants the
// first one found, i.e. the request with the minimum age.
module isq_age_pick #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic [DEPTH-1:0] req,
  input  logic [IDX_W-1:0] head,
  output logic [DEPTH-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  // Rotating priority scan from head; first hit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + IDX_W'(k);
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/isq_wksel.sv
// Age-ordered circular issue queue with tag-broadcast wakeup, oldest-first
// select into FU_N dispatch channels and branch flush by queue index.
module isq_wksel
  import is_pkg::*;
#(
  parameter int unsigned DEPTH     = ISQ_DEPTH,
  parameter int unsigned IDX_W     = ISQ_IDX_W,
  parameter int unsigned ALLOC_W   = ISQ_ALLOC_W,
  parameter int unsigned FU_N      = ISQ_FU_N,
  parameter int unsigned WAKE_N    = ISQ_WAKE_N,
  parameter int unsigned PREG_W    = ISQ_PREG_W,
  parameter int unsigned PAYLOAD_W = ISQ_PAYLOAD_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALLOC_W-1:0]            alloc_vld,
  input  logic [ALLOC_W*PAYLOAD_W-1:0]  alloc_pay,
  input  logic [ALLOC_W*(PREG_W+1)-1:0] alloc_src1,
  input  logic [ALLOC_W*(PREG_W+1)-1:0] alloc_src2,
  input  logic [ALLOC_W*FU_N-1:0]       alloc_fu,
  output logic                          alloc_rdy,
  output logic [ALLOC_W*IDX_W-1:0]      alloc_idx,
  input  logic [WAKE_N-1:0]             wake_vld,
  input  logic [WAKE_N*PREG_W-1:0]      wake_tag,
  input  logic [FU_N-1:0]               fu_rdy,
  input  logic                          flush_vld,
  input  logic [IDX_W-1:0]              flush_idx,
  output logic [FU_N-1:0]               iss_vld,
  output logic [FU_N*PAYLOAD_W-1:0]     iss_pay,
  output logic [FU_N*IDX_W-1:0]         iss_idx,
  output logic [IDX_W:0]                occupancy
);

  localparam int unsigned PEND = src_pend_pos(PREG_W);

  // Entry storage
  ent_flags_t             flg   [DEPTH];
  logic [PREG_W-1:0]      e_t1  [DEPTH];
  logic [PREG_W-1:0]      e_t2  [DEPTH];
  logic [FU_N-1:0]        e_fu  [DEPTH];
  logic [PAYLOAD_W-1:0]   e_pay [DEPTH];

  logic [IDX_W:0]         head, tail, occ;
  logic [IDX_W+1:0]       free_cnt;

  // Allocation
  logic [IDX_W-1:0]       a_slot [ALLOC_W];
  logic [ALLOC_W-1:0]     a_r1, a_r2;
  logic [IDX_W:0]         alloc_cnt;
  logic                   alloc_go;

  // Wakeup, flush, select, retire
  logic [DEPTH-1:0]       w1, w2, kill, req, picked;
  logic [DEPTH-1:0]       fu_col [FU_N];
  logic [IDX_W-1:0]       age_f, age_i;
  logic                   flush_hit;
  logic [FU_N-1:0]        sel_any;
  logic [FU_N*IDX_W-1:0]  sel_idx;
  logic [IDX_W:0]         rt_n, rt_lim;
  logic                   rt_go;
  logic [IDX_W-1:0]       rt_pos;

  // Output registers
  logic [FU_N-1:0]        iss_vld_q;
  logic [FU_N*PAYLOAD_W-1:0] iss_pay_q;
  logic [FU_N*IDX_W-1:0]  iss_idx_q;
  logic [IDX_W-1:0]       iss_age;

  function automatic logic woken(input logic [PREG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int unsigned p = 0; p < WAKE_N; p++)
      if (wake_vld[p] && (wake_tag[p*PREG_W +: PREG_W] == t)) hit = 1'b1;
    return hit;
  endfunction

  assign occ       = tail - head;
  assign occupancy = occ;
  assign free_cnt  = (IDX_W+2)'(DEPTH) - {1'b0, occ};
  assign alloc_rdy = ~flush_vld & (free_cnt >= (IDX_W+2)'(ALLOC_W));
  assign alloc_go  = alloc_rdy & (|alloc_vld);

  // Compact valid lanes onto consecutive slots from tail; resolve initial src readiness
  always_comb begin
    alloc_cnt = '0;
    alloc_idx = '0;
    for (int unsigned l = 0; l < ALLOC_W; l++) begin
      a_slot[l] = tail[IDX_W-1:0] + alloc_cnt[IDX_W-1:0];
      a_r1[l] = ~alloc_src1[l*(PREG_W+1) + PEND] |
                woken(alloc_src1[l*(PREG_W+1) + SRC_TAG_LSB +: PREG_W]);
      a_r2[l] = ~alloc_src2[l*(PREG_W+1) + PEND] |
                woken(alloc_src2[l*(PREG_W+1) + SRC_TAG_LSB +: PREG_W]);
      if (alloc_vld[l]) begin
        alloc_idx[l*IDX_W +: IDX_W] = a_slot[l];
        alloc_cnt = alloc_cnt + (IDX_W+1)'(1);
      end
    end
  end

  // Per-entry wakeup match, flush kill mask, select requests
  always_comb begin
    age_f     = flush_idx - head[IDX_W-1:0];
    flush_hit = flush_vld & ({1'b0, age_f} < occ);
    age_i     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w1[i]   = woken(e_t1[i]);
      w2[i]   = woken(e_t2[i]);
      age_i   = IDX_W'(i) - head[IDX_W-1:0];
      kill[i] = flush_hit & (age_i >= age_f);
      req[i]  = flg[i].vld & flg[i].r1 & flg[i].r2 & ~flush_vld;
      for (int unsigned f = 0; f < FU_N; f++) fu_col[f][i] = e_fu[i][f];
    end
  end

  // Picker chain: each channel sees requests not already granted to a lower channel
  for (genvar f = 0; f < FU_N; f++) begin : g_ch
    logic [DEPTH-1:0] taken_in, req_m, gnt, taken_out;
    logic [IDX_W-1:0] idx;
    logic             any;
    if (f == 0) begin : g_first
      assign taken_in = '0;
    end else begin : g_next
      assign taken_in = g_ch[f-1].taken_out;
    end
    assign req_m = req & fu_col[f] & {DEPTH{fu_rdy[f]}} & ~taken_in;
    isq_age_pick #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_pick (
      .req  (req_m),
      .head (head[IDX_W-1:0]),
      .gnt  (gnt),
      .idx  (idx),
      .any  (any)
    );
    assign taken_out = taken_in | gnt;
    assign sel_any[f] = any;
    assign sel_idx[f*IDX_W +: IDX_W] = idx;
  end
  assign picked = g_ch[FU_N-1].taken_out;

  // Head retirement: skip up to ALLOC_W invalid entries, capped at the post-flush tail
  always_comb begin
    rt_n   = '0;
    rt_go  = 1'b1;
    rt_pos = '0;
    rt_lim = flush_hit ? {1'b0, age_f} : occ;
    for (int unsigned k = 0; k < ALLOC_W; k++) begin
      rt_pos = head[IDX_W-1:0] + IDX_W'(k);
      if (rt_go && ((IDX_W+1)'(k) < rt_lim) && !flg[rt_pos].vld)
        rt_n = rt_n + (IDX_W+1)'(1);
      else
        rt_go = 1'b0;
    end
  end

  // Entry status and queue pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) flg[i] <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill[i] || picked[i]) flg[i].vld <= 1'b0;
        if (w1[i]) flg[i].r1 <= 1'b1;
        if (w2[i]) flg[i].r2 <= 1'b1;
      end
      if (alloc_go)
        for (int unsigned l = 0; l < ALLOC_W; l++)
          if (alloc_vld[l]) flg[a_slot[l]] <= ent_flags_t'{vld: 1'b1, r1: a_r1[l], r2: a_r2[l]};
      head <= head + rt_n;
      // Flushed tail is rebuilt from head so the wrap bit stays consistent with occupancy
      if (flush_hit)     tail <= head + {1'b0, age_f};
      else if (alloc_go) tail <= tail + alloc_cnt;
    end
  end

  // Entry payload and operand tags, written only on allocation
  always_ff @(posedge clk) begin
    if (alloc_go)
      for (int unsigned l = 0; l < ALLOC_W; l++)
        if (alloc_vld[l]) begin
          e_t1[a_slot[l]]  <= alloc_src1[l*(PREG_W+1) + SRC_TAG_LSB +: PREG_W];
          e_t2[a_slot[l]]  <= alloc_src2[l*(PREG_W+1) + SRC_TAG_LSB +: PREG_W];
          e_fu[a_slot[l]]  <= alloc_fu[l*FU_N +: FU_N];
          e_pay[a_slot[l]] <= alloc_pay[l*PAYLOAD_W +: PAYLOAD_W];
        end
  end

  // Issue output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld_q <= '0;
      iss_pay_q <= '0;
      iss_idx_q <= '0;
    end else begin
      iss_vld_q <= sel_any;
      for (int unsigned f = 0; f < FU_N; f++)
        if (sel_any[f]) begin
          iss_idx_q[f*IDX_W +: IDX_W]         <= sel_idx[f*IDX_W +: IDX_W];
          iss_pay_q[f*PAYLOAD_W +: PAYLOAD_W] <= e_pay[sel_idx[f*IDX_W +: IDX_W]];
        end
    end
  end

  // Squash an in-flight issue whose entry falls inside the range being flushed
  always_comb begin
    iss_age = '0;
    for (int unsigned f = 0; f < FU_N; f++) begin
      iss_age    = iss_idx_q[f*IDX_W +: IDX_W] - head[IDX_W-1:0];
      iss_vld[f] = iss_vld_q[f] &
                   ~(flush_hit & (iss_age >= age_f) & ({1'b0, iss_age} < occ));
    end
  end

  assign iss_pay = iss_pay_q;
  assign iss_idx = iss_idx_q;

endmodule
